// File: rtl/regfile_mp.sv
// Multi-read-port register file with hardwired-zero r0, busy-bit scoreboard and sweep-clear engine.
// Optional RF_BYPASS_EN forwards the same-cycle writeback to matching read ports.
module regfile_mp #(
  parameter  int unsigned XLEN  = 32,
  parameter  int unsigned NREGS = 32,
  parameter  int unsigned NRD   = 2,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [NRD*AW-1:0] raddr_i,
  output logic [NRD*XLEN-1:0] rdata_o,
  output logic [NRD-1:0]    rbusy_o,
  input  logic              rsv_valid_i,
  input  logic [AW-1:0]     rsv_addr_i,
  output logic              rsv_ready_o,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic              clr_req_i,
  output logic              clr_busy_o
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SWEEP = 1'b1;

  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic [AW-1:0]   r_idx;
  logic [AW-1:0]   w_idx_nxt;
  logic            r_clr_busy;
  logic [XLEN-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic            w_idle;
  logic            w_wr_en;
  logic            w_rsv_acc;

  assign w_idle      = (r_state == S_IDLE);
  assign w_wr_en     = w_idle & we_i & (waddr_i != '0);
  assign rsv_ready_o = rsv_valid_i & w_idle & ((rsv_addr_i == '0) | ~r_busy[rsv_addr_i]);
  assign w_rsv_acc   = rsv_ready_o & (rsv_addr_i != '0);
  assign clr_busy_o  = r_clr_busy;

  // Sweep sequencer: index starts at 1 (r0 is always zero) and stops after NREGS-1
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (clr_req_i) begin
          w_state_nxt = S_SWEEP;
          w_idx_nxt   = AW'(1);
        end
      end
      S_SWEEP: begin
        w_idx_nxt = r_idx + AW'(1);
        if (r_idx == AW'(NREGS - 1)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_clr_busy <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_clr_busy <= (w_state_nxt == S_SWEEP);
    end
  end

  // Reserve is applied after the write clear so a same-address reserve wins
  always_comb begin
    w_busy_nxt = r_busy;
    if (!w_idle) begin
      w_busy_nxt[r_idx] = 1'b0;
    end else begin
      if (w_wr_en)   w_busy_nxt[waddr_i]    = 1'b0;
      if (w_rsv_acc) w_busy_nxt[rsv_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int k = 0; k < int'(NREGS); k++) r_regs[k] <= '0;
    end else if (!w_idle) begin
      r_regs[r_idx] <= '0;
    end else if (w_wr_en) begin
      r_regs[waddr_i] <= wdata_i;
    end
  end

  for (genvar p = 0; p < int'(NRD); p++) begin : g_rd
    logic [AW-1:0] w_ra;
    assign w_ra = raddr_i[p*AW +: AW];
`ifdef RF_BYPASS_EN
    logic w_hit;
    assign w_hit = w_wr_en & (w_ra == waddr_i);
    assign rdata_o[p*XLEN +: XLEN] = (w_ra == '0) ? '0 : (w_hit ? wdata_i : r_regs[w_ra]);
    assign rbusy_o[p] = (w_ra != '0) &
                        (w_hit ? (w_rsv_acc & (rsv_addr_i == w_ra)) : r_busy[w_ra]);
`else
    assign rdata_o[p*XLEN +: XLEN] = (w_ra == '0) ? '0 : r_regs[w_ra];
    assign rbusy_o[p] = (w_ra != '0) & r_busy[w_ra];
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed checks on a 32x32/2-port instance and
// randomized model-checked traffic on a 16x64/3-port instance.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: defaults (NREGS=32, NRD=2, XLEN=32)
  logic        rst_a_n;
  logic [9:0]  a_raddr;
  logic [63:0] a_rdata;
  logic [1:0]  a_rbusy;
  logic        a_rsv_valid;
  logic [4:0]  a_rsv_addr;
  logic        a_rsv_ready;
  logic        a_we;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata;
  logic        a_clr_req;
  logic        a_clr_busy;

  regfile_mp dut_a (
    .clk_i(clk), .reset_ni(rst_a_n), .raddr_i(a_raddr), .rdata_o(a_rdata),
    .rbusy_o(a_rbusy), .rsv_valid_i(a_rsv_valid), .rsv_addr_i(a_rsv_addr),
    .rsv_ready_o(a_rsv_ready), .we_i(a_we), .waddr_i(a_waddr), .wdata_i(a_wdata),
    .clr_req_i(a_clr_req), .clr_busy_o(a_clr_busy)
  );

  // Instance B: NREGS=16, NRD=3, XLEN=64
  localparam int NB = 16;
  logic         rst_b_n;
  logic [11:0]  b_raddr;
  logic [191:0] b_rdata;
  logic [2:0]   b_rbusy;
  logic         b_rsv_valid;
  logic [3:0]   b_rsv_addr;
  logic         b_rsv_ready;
  logic         b_we;
  logic [3:0]   b_waddr;
  logic [63:0]  b_wdata;
  logic         b_clr_req;
  logic         b_clr_busy;

  regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3)) dut_b (
    .clk_i(clk), .reset_ni(rst_b_n), .raddr_i(b_raddr), .rdata_o(b_rdata),
    .rbusy_o(b_rbusy), .rsv_valid_i(b_rsv_valid), .rsv_addr_i(b_rsv_addr),
    .rsv_ready_o(b_rsv_ready), .we_i(b_we), .waddr_i(b_waddr), .wdata_i(b_wdata),
    .clr_req_i(b_clr_req), .clr_busy_o(b_clr_busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [4:0] ad, input logic [31:0] d);
    a_we = 1'b1; a_waddr = ad; a_wdata = d;
    step();
    a_we = 1'b0;
  endtask

  // Reference model for B: register contents, busy flags and sweep progress
  logic [63:0] m_reg  [NB];
  logic        m_busy [NB];
  int          m_next;  // next register the sweep will zero, 0 when not sweeping

  always @(posedge clk or negedge rst_b_n) begin
    if (!rst_b_n) begin
      for (int k = 0; k < NB; k++) begin
        m_reg[k]  <= '0;
        m_busy[k] <= 1'b0;
      end
      m_next <= 0;
    end else if (m_next != 0) begin
      m_reg[m_next]  <= '0;
      m_busy[m_next] <= 1'b0;
      m_next <= (m_next == NB - 1) ? 0 : m_next + 1;
    end else begin
      if (b_we && b_waddr != 0) begin
        m_reg[b_waddr]  <= b_wdata;
        m_busy[b_waddr] <= 1'b0;
      end
      if (b_rsv_valid && b_rsv_addr != 0 && !m_busy[b_rsv_addr]) m_busy[b_rsv_addr] <= 1'b1;
      if (b_clr_req) m_next <= 1;
    end
  end

  // Compare B against the model mid-cycle
  always @(negedge clk) begin
    logic [63:0] er;
    logic [2:0]  eb;
    logic        erdy;
    int          a;
    erdy = b_rsv_valid && (m_next == 0) && (b_rsv_addr == 0 || !m_busy[b_rsv_addr]);
    for (int p = 0; p < 3; p++) begin
      a = int'(b_raddr[p*4 +: 4]);
      if (a == 0) begin
        er = '0; eb[p] = 1'b0;
      end else begin
        er = m_reg[a]; eb[p] = m_busy[a];
`ifdef RF_BYPASS_EN
        if (m_next == 0 && b_we && int'(b_waddr) == a) begin
          er = b_wdata;
          eb[p] = erdy && int'(b_rsv_addr) == a;
        end
`endif
      end
      chk($sformatf("B rdata%0d", p), b_rdata[p*64 +: 64], er);
    end
    chk("B rbusy", 64'(b_rbusy), 64'(eb));
    chk("B rsv_ready", 64'(b_rsv_ready), 64'(erdy));
    chk("B clr_busy", 64'(b_clr_busy), 64'(m_next != 0));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    a_raddr = '0; a_rsv_valid = 0; a_rsv_addr = '0; a_we = 0; a_waddr = '0; a_wdata = '0; a_clr_req = 0;
    b_raddr = '0; b_rsv_valid = 0; b_rsv_addr = '0; b_we = 0; b_waddr = '0; b_wdata = '0; b_clr_req = 0;

    // Reset state of A
    #3;
    a_rsv_valid = 1; a_rsv_addr = 5'd3; a_raddr = {5'd2, 5'd1};
    #1;
    chk("A reset rdata", a_rdata, 64'h0);
    chk("A reset rbusy", 64'(a_rbusy), 64'h0);
    chk("A reset clr_busy", 64'(a_clr_busy), 64'h0);
    chk("A reset rsv_ready", 64'(a_rsv_ready), 64'h1);
    a_rsv_valid = 0;
    step(); step();
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    step();

    // Write/read and zero register
    a_write(5'd5, 32'hDEADBEEF);
    a_raddr = {5'd5, 5'd5};
    #2;
    chk("A rd5 port0", 64'(a_rdata[31:0]), 64'hDEADBEEF);
    chk("A rd5 port1", 64'(a_rdata[63:32]), 64'hDEADBEEF);
    a_write(5'd0, 32'h12345678);
    a_raddr = {5'd0, 5'd0};
    #2;
    chk("A r0 zero", a_rdata, 64'h0);

    // Bypass / write-then-read timing on reg 12
    a_write(5'd12, 32'h11111111);
    a_we = 1; a_waddr = 5'd12; a_wdata = 32'hCAFEF00D; a_raddr = {5'd12, 5'd0};
    #2;
`ifdef RF_BYPASS_EN
    chk("A bypass same cycle", 64'(a_rdata[63:32]), 64'hCAFEF00D);
`else
    chk("A old value same cycle", 64'(a_rdata[63:32]), 64'h11111111);
`endif
    step();
    a_we = 0;
    #2;
    chk("A rd12 next cycle", 64'(a_rdata[63:32]), 64'hCAFEF00D);

    // Scoreboard on reg 7
    a_raddr = {5'd0, 5'd7}; a_rsv_valid = 1; a_rsv_addr = 5'd7;
    #2;
    chk("A rsv7 ready", 64'(a_rsv_ready), 64'h1);
    step();
    #2;
    chk("A rbusy7 set", 64'(a_rbusy[0]), 64'h1);
    chk("A rsv7 refused", 64'(a_rsv_ready), 64'h0);
    step();
    a_rsv_valid = 0;
    a_write(5'd7, 32'h77);
    #2;
    chk("A rbusy7 cleared", 64'(a_rbusy[0]), 64'h0);
    chk("A rd7", 64'(a_rdata[31:0]), 64'h77);

    // Same-cycle write+reserve on reg 9, idle then busy
    a_raddr = {5'd9, 5'd0};
    a_we = 1; a_waddr = 5'd9; a_wdata = 32'h99; a_rsv_valid = 1; a_rsv_addr = 5'd9;
    #2;
    chk("A wr+rsv9 ready", 64'(a_rsv_ready), 64'h1);
    step();
    a_we = 0; a_rsv_valid = 0;
    #2;
    chk("A wr+rsv9 data", 64'(a_rdata[63:32]), 64'h99);
    chk("A wr+rsv9 busy", 64'(a_rbusy[1]), 64'h1);
    a_we = 1; a_waddr = 5'd9; a_wdata = 32'hAA; a_rsv_valid = 1; a_rsv_addr = 5'd9;
    #2;
    chk("A wr+rsv9 busy refused", 64'(a_rsv_ready), 64'h0);
    step();
    a_we = 0; a_rsv_valid = 0;
    #2;
    chk("A wr+rsv9 busy cleared", 64'(a_rbusy[1]), 64'h0);
    chk("A wr+rsv9 data2", 64'(a_rdata[63:32]), 64'hAA);

    // Sweep clear of the 32-entry file
    for (int k = 1; k < 32; k++) a_write(5'(k), 32'(k));
    a_clr_req = 1;
    step();
    a_clr_req = 0; a_rsv_valid = 1; a_rsv_addr = 5'd4; a_raddr = {5'd10, 5'd3};
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      #2;
      if (a_clr_busy) begin
        cnt++;
        chk("A rsv_ready during sweep", 64'(a_rsv_ready), 64'h0);
      end
      if (c == 2) chk("A reg3 before clear", 64'(a_rdata[31:0]), 64'h3);
      if (c == 3) chk("A reg3 cleared", 64'(a_rdata[31:0]), 64'h0);
      a_we = (c == 20); a_waddr = 5'd10; a_wdata = 32'hBAD;
      step();
    end
    a_we = 0; a_rsv_valid = 0;
    #2;
    chk("A sweep length", 64'(cnt), 64'd31);
    chk("A reg10 write dropped", 64'(a_rdata[63:32]), 64'h0);

    // Asynchronous reset in the middle of a sweep
    for (int k = 1; k < 32; k++) a_write(5'(k), 32'hA5A5A5A5);
    a_rsv_valid = 1; a_rsv_addr = 5'd31;
    step();
    a_rsv_valid = 0;
    a_clr_req = 1;
    step();
    a_clr_req = 0;
    for (int k = 0; k < 5; k++) step();
    a_raddr = {5'd31, 5'd20};
    #2;
    chk("A pre-reset rd20", 64'(a_rdata[31:0]), 64'hA5A5A5A5);
    chk("A pre-reset busy31", 64'(a_rbusy[1]), 64'h1);
    chk("A pre-reset clr_busy", 64'(a_clr_busy), 64'h1);
    rst_a_n = 1'b0;
    #1;
    chk("A async reset rdata", a_rdata, 64'h0);
    chk("A async reset rbusy", 64'(a_rbusy), 64'h0);
    chk("A async reset clr_busy", 64'(a_clr_busy), 64'h0);
    step();
    rst_a_n = 1'b1;

    // B: literal pins for the model
    b_we = 1; b_waddr = 4'd15; b_wdata = 64'h0123_4567_89AB_CDEF; b_raddr = {4'd15, 4'd0, 4'd0};
    step();
    b_we = 0;
    #2;
    chk("B rd15 literal", b_rdata[191:128], 64'h0123_4567_89AB_CDEF);
    chk("B model reg15 literal", m_reg[15], 64'h0123_4567_89AB_CDEF);
    b_rsv_valid = 1; b_rsv_addr = 4'd15;
    step();
    b_rsv_valid = 0;
    #2;
    chk("B busy15 literal", 64'(b_rbusy[2]), 64'h1);

    // B: random traffic
    for (int i = 0; i < 3000; i++) begin
      for (int p = 0; p < 3; p++) b_raddr[p*4 +: 4] = 4'($urandom_range(0, 15));
      b_we        = ($urandom % 2) == 0;
      b_waddr     = 4'($urandom_range(0, 15));
      b_wdata     = {$urandom, $urandom};
      b_rsv_valid = ($urandom % 3) == 0;
      b_rsv_addr  = (($urandom % 4) == 0) ? b_waddr : 4'($urandom_range(0, 15));
      if (($urandom % 4) == 0) b_raddr[3:0] = b_waddr;
      b_clr_req   = ($urandom % 80) == 0;
      step();
    end
    b_we = 0; b_rsv_valid = 0; b_clr_req = 0;
    for (int k = 0; k < 20; k++) step();

    // B: sweep lasts NREGS-1 = 15 cycles
    b_clr_req = 1;
    step();
    b_clr_req = 0;
    cnt = 0;
    for (int c = 0; c < 25; c++) begin
      #2;
      if (b_clr_busy) cnt++;
      step();
    end
    chk("B sweep length", 64'(cnt), 64'd15);

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
